// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART TX buffering path and the MMIO status register.
// Bit positions here are the single source of truth for the status decoder.
package uart_tx_fifo_pkg;

    localparam int unsigned UART_DATA_WIDTH    = 8;
    localparam int unsigned UART_TX_FIFO_DEPTH = 8;

    // MMIO status register bit positions
    localparam int unsigned UART_STAT_TX_FULL_BIT  = 0;
    localparam int unsigned UART_STAT_TX_EMPTY_BIT = 1;

    typedef struct packed {
        logic empty;
        logic full;
    } uart_tx_status_t;

    function automatic uart_tx_status_t uart_tx_status(input logic full, input logic empty);
        uart_tx_status_t s;
        s.full  = full;
        s.empty = empty;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module uart_tx_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// Optional zero-latency empty bypass: define UART_TX_FIFO_BYPASS_EN.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       enq_data,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    output logic [WIDTH-1:0]       deq_data,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_data;
    logic             enq_fire;
    logic             deq_fire;

    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign enq_ready = !full;
    assign deq_fire  = deq_ready && !empty;

`ifdef UART_TX_FIFO_BYPASS_EN
    logic bypass_take;

    // An empty FIFO hands the incoming byte straight to a ready transmitter.
    assign bypass_take = empty && enq_valid && deq_ready;
    assign enq_fire    = enq_valid && !full && !bypass_take;
    assign deq_valid   = empty ? (enq_valid && !reset) : 1'b1;
    assign deq_data    = empty ? enq_data : head_data;
`else
    assign enq_fire    = enq_valid && !full;
    assign deq_valid   = !empty;
    assign deq_data    = head_data;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    uart_tx_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (enq_fire),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i(enq_data),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(head_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table for fill/drain, directed
// sequences for async reset, streaming wrap-around and enqueue latency.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] enq_data;
    logic       enq_valid;
    logic       enq_ready;
    logic [7:0] deq_data;
    logic       deq_valid;
    logic       deq_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int n_cmp;
    int n_err;

    uart_tx_fifo #(
        .WIDTH(8),
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enq_data (enq_data),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .deq_data (deq_data),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ev;
        logic [7:0] d;
        logic       dr;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_valid;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, " count"}, 32'(count), 32'd0);
        check({tag, " empty"}, 32'(empty), 32'd1);
        check({tag, " full"}, 32'(full), 32'd0);
        check({tag, " enq_ready"}, 32'(enq_ready), 32'd1);
        check({tag, " deq_valid"}, 32'(deq_valid), 32'd0);
    endtask

    logic [7:0] model_q[$];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        enq_data  = 8'h00;
        enq_valid = 1'b0;
        deq_ready = 1'b0;

        // Fill 0x41..0x48, then a dropped 9th write
        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{1'b1, 8'(8'h41 + i), 1'b0, (i < 8) ? 4'(i + 1) : 4'd8,
                        (i >= 7), 1'b1, 8'h41};
        end
        // At full: write while draining must be dropped
        vecs[9] = '{1'b1, 8'h99, 1'b1, 4'd7, 1'b0, 1'b1, 8'h42};
        for (int i = 10; i < 17; i++) begin
            vecs[i] = '{1'b0, 8'h00, 1'b1, 4'(16 - i), 1'b0, (i < 16), 8'(8'h43 + (i - 10))};
        end
        // deq_ready on an empty FIFO is ignored
        vecs[17] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00};

        #3;
        check_idle_flags("reset0");
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            enq_valid = vecs[k].ev;
            enq_data  = vecs[k].d;
            deq_ready = vecs[k].dr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d count", k), 32'(count), 32'(vecs[k].exp_count));
            check($sformatf("vec%0d full", k), 32'(full), 32'(vecs[k].exp_full));
            check($sformatf("vec%0d enq_ready", k), 32'(enq_ready), 32'(!vecs[k].exp_full));
            check($sformatf("vec%0d deq_valid", k), 32'(deq_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d empty", k), 32'(empty), 32'(vecs[k].exp_count == 0));
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d deq_data", k), 32'(deq_data), 32'(vecs[k].exp_head));
            end
        end

        // Async reset between edges while holding data
        @(negedge clk);
        enq_valid = 1'b1;
        deq_ready = 1'b0;
        enq_data  = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset count", 32'(count), 32'd3);
        @(negedge clk);
        enq_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle_flags("async reset");
        @(negedge clk);
        reset = 1'b0;

        // Preload 3 then stream 20 cycles of simultaneous enq/deq
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enq_valid = 1'b1;
            enq_data  = 8'(8'h10 + i);
            model_q.push_back(8'(8'h10 + i));
            @(posedge clk);
        end
        #1;
        check("preload count", 32'(count), 32'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enq_valid = 1'b1;
            enq_data  = 8'(8'h13 + i);
            deq_ready = 1'b1;
            #1;
            check($sformatf("stream%0d deq_data", i), 32'(deq_data), 32'(model_q[0]));
            @(posedge clk);
            void'(model_q.pop_front());
            model_q.push_back(8'(8'h13 + i));
            #1;
            check($sformatf("stream%0d count", i), 32'(count), 32'd3);
        end
        @(negedge clk);
        enq_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("tail%0d deq_data", i), 32'(deq_data), 32'(model_q[0]));
            @(posedge clk);
            void'(model_q.pop_front());
            @(negedge clk);
        end
        check("tail empty", 32'(empty), 32'd1);

        // Enqueue latency into an empty FIFO with a ready consumer
        @(negedge clk);
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 8'h5A;
        #1;
`ifdef UART_TX_FIFO_BYPASS_EN
        check("bypass deq_valid", 32'(deq_valid), 32'd1);
        check("bypass deq_data", 32'(deq_data), 32'h5A);
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        #1;
        check("bypass count", 32'(count), 32'd0);
        check("bypass deq_valid after", 32'(deq_valid), 32'd0);
`else
        check("latency same-cycle deq_valid", 32'(deq_valid), 32'd0);
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        #1;
        check("latency count", 32'(count), 32'd1);
        check("latency deq_valid", 32'(deq_valid), 32'd1);
        check("latency deq_data", 32'(deq_data), 32'h5A);
        @(posedge clk);
        #1;
        check("latency drained", 32'(count), 32'd0);
        check("latency deq_valid low", 32'(deq_valid), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
